bola_nave: RTL and testbench
============================

Name: bola_nave

Overview:
- Player-ship projectile generator. Drives the `x_bola_nave`/`y_bola_nave` bus that every `inimigo` instance samples for collision.
- On a fire press it launches one shot from the ship's nose and moves it upward on a divided tick.
- It retires the shot at the screen top or when any enemy reports a hit, then enforces a reload delay.
- Sits beside the ship controller. Its outputs fan out to all enemy instances; the OR of their kill pulses returns as `acerto`.

Parameters:
- DIV_TICK, 320000: CLOCK_50 cycles per movement tick.
- VELOCIDADE, 4: pixels moved upward per tick.
- OFFSET_X, 16: added to x_nave at launch (ship centre).
- Y_TOPO, 0: top boundary row.
- RECARGA_TICKS, 8: ticks spent in reload before the next shot is allowed.
- Y_ESTACIONADA, 1023: parked y value when no shot is in flight (off-screen, below every enemy).

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-low reset.
- pausa  in  1  freezes tick-driven movement and reload.
- reiniciarJogo  in  1  synchronous game restart, same effect as reset.
- disparo  in  1  fire button, asynchronous level, active-high.
- x_nave  in  10  ship x position.
- y_nave  in  10  ship y position.
- acerto  in  1  OR of enemy kill pulses, high at least 1 cycle.
- x_bola_nave  out  10  shot x position.
- y_bola_nave  out  10  shot y position; equals Y_ESTACIONADA when idle.
- ativa  out  1  high while a shot is in flight.

Behaviour:
- Reset values (reset=0, or reiniciarJogo=1 at a clock edge):
  - state PRONTA, ativa=0, x_bola_nave=0, y_bola_nave=Y_ESTACIONADA.
  - tick counter, reload counter and synchroniser all cleared.
- Tick generation:
  - Counter runs 0..DIV_TICK-1 on CLOCK_50.
  - tick is a 1-cycle pulse at wrap.
  - Counter keeps running during pausa, but tick has no effect while pausa=1.
- Fire input path:
  - disparo passes through a 2-FF synchroniser, then rising-edge detection.
  - The resulting fire event is 1 cycle long, 3 cycles after the input edge.
- State machine (transitions take effect on the clock edge):
  - PRONTA: on fire event, regardless of pausa:
    - x_bola_nave <= x_nave+OFFSET_X (10-bit wrap); y_bola_nave <= y_nave; ativa <= 1; go to VOANDO.
    - Fire events in any other state are discarded, not queued.
  - VOANDO, priority order:
    1. acerto=1 (honoured even during pausa): go to RECARGA.
    2. tick and pausa=0 with y_bola_nave < Y_TOPO+VELOCIDADE: go to RECARGA (no underflow wrap).
    3. tick and pausa=0 otherwise: y_bola_nave <= y_bola_nave-VELOCIDADE.
    - x_bola_nave is constant during flight.
  - Entering RECARGA: ativa<=0, y_bola_nave<=Y_ESTACIONADA, x_bola_nave held, reload counter<=0.
  - RECARGA: each tick with pausa=0 increments the reload counter. At RECARGA_TICKS go to PRONTA.
- Simultaneous events and timing:
  - acerto and tick in the same cycle: acerto wins, no move.
  - Fire event and reiniciarJogo together: restart wins.
  - Latency from acerto high to ativa=0 and y parked is 1 cycle.
  - reset asserted mid-flight clears immediately (asynchronous).
- Outputs are registered only; no combinational path from inputs.

Optional Feature:
- Macro: DISPARO_AUTO_EN.
- Defined: in PRONTA, a synchronised disparo level of 1 also counts as a fire event. Holding the button auto-fires once per reload period.
- Undefined: only rising edges fire; holding the button yields exactly one shot.

Test Plan:
Bench uses DIV_TICK=4, VELOCIDADE=4, OFFSET_X=16, RECARGA_TICKS=2.
- Reset release, no input:
  - ativa=0, y_bola_nave=1023, x_bola_nave=0 held for 100 cycles.
- Launch and climb:
  - x_nave=100, y_nave=440, pulse disparo → 3 cycles later ativa=1, x=116, y=440.
  - After 5 ticks y=420.
- Top retirement:
  - Launch at y_nave=10 → ticks give y=6, then y=2.
  - Next tick: ativa=0, y=1023.
  - 2 ticks later PRONTA; a new press launches.
- Hit, pause and press-ignore:
  - acerto pulse mid-flight → next cycle ativa=0, y=1023.
  - disparo pressed during RECARGA produces no shot.
  - pausa=1 in flight freezes y across 10 ticks; acerto during pausa still retires the shot.
- Restart mid-flight:
  - reiniciarJogo=1 for 1 cycle → ativa=0, y=1023, PRONTA.
  - Asynchronous reset=0 mid-cycle clears outputs before the next edge.
- Macro:
  - With DISPARO_AUTO_EN and disparo held high: shots relaunch every flight+2 ticks.
  - Without the macro: exactly one shot.

Source files
------------

// File: rtl/bola_nave_if.sv
// Coordinate bus between the ship-side logic and the projectile generator.
// The projectile drives x/y/ativa; the ship side drives fire, ship position and the OR'd enemy hit.
interface bola_nave_if;
    // No back-pressure on this bus. ativa qualifies x_bola_nave/y_bola_nave.
    // While ativa=0, y_bola_nave is parked below every enemy, so no collision can fire.
    logic       disparo;
    logic [9:0] x_nave;
    logic [9:0] y_nave;
    logic       acerto;
    logic [9:0] x_bola_nave;
    logic [9:0] y_bola_nave;
    logic       ativa;

    modport master (
        output disparo, x_nave, y_nave, acerto,
        input  x_bola_nave, y_bola_nave, ativa
    );

    modport slave (
        input  disparo, x_nave, y_nave, acerto,
        output x_bola_nave, y_bola_nave, ativa
    );
endinterface

// File: rtl/bola_nave.sv
// Player-ship projectile: launch on fire, climb on a divided tick, retire on hit or at the top, then reload.
// Optional macro DISPARO_AUTO_EN: a held fire button re-fires whenever the generator is ready.
module bola_nave #(
    parameter int DIV_TICK      = 320000,
    parameter int VELOCIDADE    = 4,
    parameter int OFFSET_X      = 16,
    parameter int Y_TOPO        = 0,
    parameter int RECARGA_TICKS = 8,
    parameter int Y_ESTACIONADA = 1023
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             pausa,
    input  logic             reiniciarJogo,
    bola_nave_if.slave       bus,
    output logic [1:0]       estado
);

    typedef enum logic [1:0] {
        PRONTA  = 2'd0,
        VOANDO  = 2'd1,
        RECARGA = 2'd2
    } estado_t;

    localparam int TW = (DIV_TICK > 1) ? $clog2(DIV_TICK) : 1;
    localparam int RW = (RECARGA_TICKS > 1) ? $clog2(RECARGA_TICKS + 1) : 1;
    localparam logic [10:0] LIMITE = 11'(Y_TOPO + VELOCIDADE);

    estado_t         state_q, state_d;
    logic [9:0]      x_q, x_d;
    logic [9:0]      y_q, y_d;
    logic            ativa_q, ativa_d;
    logic [RW-1:0]   rc_q, rc_d;
    logic [TW-1:0]   tick_cnt;
    logic            tick;
    logic            mover;
    logic            sync1, sync2;
    logic            fire;
    logic            no_topo;

    // Counter free-runs during pausa; pausa only gates what the tick is allowed to do.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
        end else if (reiniciarJogo) begin
            tick_cnt <= '0;
        end else if (tick_cnt == TW'(DIV_TICK - 1)) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign tick  = (tick_cnt == TW'(DIV_TICK - 1));
    assign mover = tick & ~pausa;

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else if (reiniciarJogo) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= bus.disparo;
            sync2 <= sync1;
        end
    end

`ifdef DISPARO_AUTO_EN
    assign fire = sync2;
`else
    logic sync_prev;

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            sync_prev <= 1'b0;
        end else if (reiniciarJogo) begin
            sync_prev <= 1'b0;
        end else begin
            sync_prev <= sync2;
        end
    end

    assign fire = sync2 & ~sync_prev;
`endif

    // Widened compare so the last step retires instead of wrapping below zero.
    assign no_topo = ({1'b0, y_q} < LIMITE);

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        ativa_d = ativa_q;
        rc_d    = rc_q;
        case (state_q)
            PRONTA: begin
                if (fire) begin
                    x_d     = bus.x_nave + 10'(OFFSET_X);
                    y_d     = bus.y_nave;
                    ativa_d = 1'b1;
                    state_d = VOANDO;
                end
            end
            VOANDO: begin
                if (bus.acerto || (mover && no_topo)) begin
                    ativa_d = 1'b0;
                    y_d     = 10'(Y_ESTACIONADA);
                    rc_d    = '0;
                    state_d = RECARGA;
                end else if (mover) begin
                    y_d = y_q - 10'(VELOCIDADE);
                end
            end
            RECARGA: begin
                if (mover) begin
                    if (rc_q == RW'(RECARGA_TICKS - 1)) begin
                        rc_d    = '0;
                        state_d = PRONTA;
                    end else begin
                        rc_d = rc_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = PRONTA;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q <= PRONTA;
            x_q     <= '0;
            y_q     <= 10'(Y_ESTACIONADA);
            ativa_q <= 1'b0;
            rc_q    <= '0;
        end else if (reiniciarJogo) begin
            state_q <= PRONTA;
            x_q     <= '0;
            y_q     <= 10'(Y_ESTACIONADA);
            ativa_q <= 1'b0;
            rc_q    <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            ativa_q <= ativa_d;
            rc_q    <= rc_d;
        end
    end

    assign bus.x_bola_nave = x_q;
    assign bus.y_bola_nave = y_q;
    assign bus.ativa       = ativa_q;
    assign estado          = state_q;

endmodule

// File: tb/tb_bola_nave.sv
// Bench for bola_nave: cycle model of the shot rules compared every cycle, plus directed literal checks.
module tb_bola_nave;

    localparam int DIV   = 4;
    localparam int VEL   = 4;
    localparam int OFFX  = 16;
    localparam int RELOD = 2;
    localparam int PARK  = 1023;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pausa = 1'b0;
    logic       reiniciar = 1'b0;
    logic [1:0] estado;

    bola_nave_if bus ();

    bola_nave #(
        .DIV_TICK(DIV),
        .VELOCIDADE(VEL),
        .OFFSET_X(OFFX),
        .Y_TOPO(0),
        .RECARGA_TICKS(RELOD),
        .Y_ESTACIONADA(PARK)
    ) dut (
        .CLOCK_50(clk),
        .reset(rst_n),
        .pausa(pausa),
        .reiniciarJogo(reiniciar),
        .bus(bus),
        .estado(estado)
    );

    // ---------------- clock / reset ----------------
    always #10 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    int total = 0;
    int bad = 0;
    int shown = 0;
    bit check_en = 1'b0;

    // ---------------- behavioural model ----------------
    int         m_edges;
    bit         m_hist[3];
    bit         m_ready;
    bit         m_fly;
    int         m_reload;
    int         m_x;
    int         m_y;

    task automatic model_reset();
        m_edges  = 0;
        m_hist[0] = 1'b0;
        m_hist[1] = 1'b0;
        m_hist[2] = 1'b0;
        m_ready  = 1'b1;
        m_fly    = 1'b0;
        m_reload = 0;
        m_x      = 0;
        m_y      = PARK;
    endtask

    always @(posedge clk or negedge rst_n) begin
        bit tk;
        bit go;
        if (!rst_n || reiniciar) begin
            model_reset();
        end else begin
            tk = ((m_edges % DIV) == DIV - 1) && !pausa;
            m_edges++;
`ifdef DISPARO_AUTO_EN
            go = m_hist[1];
`else
            go = m_hist[1] && !m_hist[2];
`endif
            m_hist[2] = m_hist[1];
            m_hist[1] = m_hist[0];
            m_hist[0] = bus.disparo;
            if (m_ready) begin
                if (go) begin
                    m_ready = 1'b0;
                    m_fly   = 1'b1;
                    m_x     = (int'(bus.x_nave) + OFFX) % 1024;
                    m_y     = int'(bus.y_nave);
                end
            end else if (m_fly) begin
                if (bus.acerto || (tk && m_y < VEL)) begin
                    m_fly    = 1'b0;
                    m_y      = PARK;
                    m_reload = 0;
                end else if (tk) begin
                    m_y = m_y - VEL;
                end
            end else if (tk) begin
                m_reload++;
                if (m_reload == RELOD) m_ready = 1'b1;
            end
        end
    end

    // ---------------- scoreboard compare ----------------
    always @(posedge clk) begin
        #1;
        if (rst_n && check_en) begin
            total++;
            if (bus.ativa !== m_fly || bus.x_bola_nave !== 10'(m_x) ||
                bus.y_bola_nave !== 10'(m_y)) begin
                bad++;
                if (shown < 20) begin
                    shown++;
                    $display("FAIL model t=%0t: got ativa=%0b x=%0d y=%0d want ativa=%0b x=%0d y=%0d",
                             $time, bus.ativa, bus.x_bola_nave, bus.y_bola_nave, m_fly, m_x, m_y);
                end
            end
        end
    end

    // ---------------- driver / check tasks ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic press();
        bus.disparo = 1'b1;
        @(negedge clk);
        bus.disparo = 1'b0;
    endtask

    task automatic hit();
        bus.acerto = 1'b1;
        @(negedge clk);
        bus.acerto = 1'b0;
    endtask

    task automatic wait_ativa(input logic val, input int budget, input string name);
        int k = 0;
        while (bus.ativa !== val && k < budget) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (bus.ativa !== val) begin
            bad++;
            $display("FAIL %s: got ativa=%0b want %0b within %0d cycles", name, bus.ativa, val, budget);
        end
    endtask

    task automatic wait_y_change(input int old, input int budget, input string name);
        int k = 0;
        while (int'(bus.y_bola_nave) == old && k < budget) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (int'(bus.y_bola_nave) == old) begin
            bad++;
            $display("FAIL %s: got y=%0d still, want change within %0d cycles", name, old, budget);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int frozen_y;
        int launches;
        logic prev_ativa;

        bus.disparo = 1'b0;
        bus.x_nave  = '0;
        bus.y_nave  = '0;
        bus.acerto  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_en = 1'b1;

        repeat (100) @(negedge clk);
        chk("idle_ativa", bus.ativa, 0);
        chk("idle_y", bus.y_bola_nave, 1023);
        chk("idle_x", bus.x_bola_nave, 0);

        bus.x_nave = 10'd100;
        bus.y_nave = 10'd440;
        press();
        @(negedge clk);
        chk("launch_not_yet", bus.ativa, 0);
        @(negedge clk);
        chk("launch_ativa", bus.ativa, 1);
        chk("launch_x", bus.x_bola_nave, 116);
        chk("launch_y", bus.y_bola_nave, 440);
        repeat (20) @(negedge clk);
        chk("climb_5_ticks", bus.y_bola_nave, 420);

        hit();
        chk("hit_ativa", bus.ativa, 0);
        chk("hit_y", bus.y_bola_nave, 1023);
        chk("hit_x_held", bus.x_bola_nave, 116);
        press();
        repeat (12) @(negedge clk);
        chk("reload_press_ignored", bus.ativa, 0);

        bus.x_nave = 10'd50;
        bus.y_nave = 10'd10;
        press();
        wait_ativa(1'b1, 10, "top_launch");
        chk("top_x", bus.x_bola_nave, 66);
        chk("top_y0", bus.y_bola_nave, 10);
        wait_y_change(10, 8, "top_step1");
        chk("top_y1", bus.y_bola_nave, 6);
        wait_y_change(6, 8, "top_step2");
        chk("top_y2", bus.y_bola_nave, 2);
        wait_y_change(2, 8, "top_step3");
        chk("top_retire_ativa", bus.ativa, 0);
        chk("top_retire_y", bus.y_bola_nave, 1023);
        repeat (10) @(negedge clk);

        bus.x_nave = 10'd0;
        bus.y_nave = 10'd200;
        press();
        wait_ativa(1'b1, 10, "relaunch");
        chk("relaunch_y", bus.y_bola_nave, 200);
        chk("relaunch_x", bus.x_bola_nave, 16);
        repeat (6) @(negedge clk);
        pausa = 1'b1;
        @(negedge clk);
        frozen_y = m_y;
        repeat (40) @(negedge clk);
        chk("pause_freeze_y", bus.y_bola_nave, frozen_y);
        chk("pause_still_flying", bus.ativa, 1);
        hit();
        chk("pause_hit_ativa", bus.ativa, 0);
        chk("pause_hit_y", bus.y_bola_nave, 1023);
        repeat (20) @(negedge clk);
        press();
        repeat (6) @(negedge clk);
        chk("pause_reload_frozen", bus.ativa, 0);
        pausa = 1'b0;
        repeat (12) @(negedge clk);

        bus.x_nave = 10'd300;
        bus.y_nave = 10'd300;
        press();
        wait_ativa(1'b1, 10, "restart_launch");
        repeat (5) @(negedge clk);
        reiniciar = 1'b1;
        @(negedge clk);
        reiniciar = 1'b0;
        chk("restart_ativa", bus.ativa, 0);
        chk("restart_y", bus.y_bola_nave, 1023);
        chk("restart_x", bus.x_bola_nave, 0);
        press();
        wait_ativa(1'b1, 10, "restart_ready");
        chk("restart_relaunch_x", bus.x_bola_nave, 316);
        hit();
        repeat (12) @(negedge clk);

        bus.disparo = 1'b1;
        @(negedge clk);
        bus.disparo = 1'b0;
        @(negedge clk);
        reiniciar = 1'b1;
        @(negedge clk);
        reiniciar = 1'b0;
        chk("restart_beats_fire", bus.ativa, 0);
        repeat (6) @(negedge clk);
        chk("restart_fire_dropped", bus.ativa, 0);

        press();
        wait_ativa(1'b1, 10, "async_launch");
        repeat (3) @(negedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_ativa", bus.ativa, 0);
        chk("async_y", bus.y_bola_nave, 1023);
        chk("async_x", bus.x_bola_nave, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        bus.x_nave = 10'd0;
        bus.y_nave = 10'd40;
        bus.disparo = 1'b1;
        launches = 0;
        prev_ativa = bus.ativa;
        repeat (300) begin
            @(negedge clk);
            if (bus.ativa === 1'b1 && prev_ativa === 1'b0) launches++;
            prev_ativa = bus.ativa;
        end
        bus.disparo = 1'b0;
`ifdef DISPARO_AUTO_EN
        chk("hold_autofire_many", launches >= 2, 1);
`else
        chk("hold_single_shot", launches, 1);
`endif
        repeat (4) @(negedge clk);

        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
